// File: rtl/synchronizer_pkg.sv
// Shared defaults for the multi-bit flip-flop synchronizer and its users.
// Holds default depth/width constants and the minimum legal depth.
// No ports; imported with import synchronizer_pkg::*.
package synchronizer_pkg;

   // Default number of flip-flop stages per bit.
   localparam int SYNC_NUM_STAGES_DFLT = 2;
   // Default number of independently synchronized bits.
   localparam int SYNC_WIDTH_DFLT      = 1;
   // Fewer than two stages gives no metastability settling time.
   localparam int SYNC_NUM_STAGES_MIN  = 2;
   localparam int SYNC_WIDTH_MIN       = 1;

endpackage

// File: rtl/synchronizer_bit_sync_cell.sv
// Single-bit synchronizer: NUM_Stages-deep D flip-flop chain clocked by CLK.
// Ports: CLK (dest clock), Reset (sync, active-high), async_i (raw bit),
//        sync_o (last stage register, no combinational path from async_i).
module bit_sync_cell
   import synchronizer_pkg::*;
#(
   parameter int NUM_Stages = SYNC_NUM_STAGES_DFLT
) (
   input  logic CLK,
   input  logic Reset,
   input  logic async_i,
   output logic sync_o
);

   if (NUM_Stages < SYNC_NUM_STAGES_MIN) begin : g_bad_stages
      $error("bit_sync_cell: NUM_Stages must be at least 2");
   end

   // Stage 0 is the capture flop and may go metastable; the remaining stages
   // give it time to settle. Attributes keep the chain packed together and
   // stop retiming, duplication or SRL extraction from breaking it up.
   (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO", DONT_TOUCH = "TRUE" *)
   logic [NUM_Stages-1:0] stage_q;
   logic [NUM_Stages-1:0] stage_d;

   // Bit 0 is the capture stage; higher indices are further down the chain.
   always_comb begin
      stage_d = {stage_q[NUM_Stages-2:0], async_i};
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign sync_o = stage_q[NUM_Stages-1];

endmodule

// File: rtl/synchronizer.sv
// Multi-bit flip-flop synchronizer: one independent chain per bit, no coherency.
// Ports: CLK (dest clock), Reset (sync, active-high), Async_data [Width] (any
//        domain), sync_data [Width] (registered, NUM_Stages edges of latency).
module synchronizer
   import synchronizer_pkg::*;
#(
   parameter int NUM_Stages = SYNC_NUM_STAGES_DFLT,
   parameter int Width      = SYNC_WIDTH_DFLT
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic [Width-1:0] Async_data,
   output logic [Width-1:0] sync_data
);

   if (NUM_Stages < SYNC_NUM_STAGES_MIN) begin : g_bad_stages
      $error("synchronizer: NUM_Stages must be at least 2");
   end

   if (Width < SYNC_WIDTH_MIN) begin : g_bad_width
      $error("synchronizer: Width must be at least 1");
   end

   // Bits are deliberately independent: a multi-bit value is only coherent at
   // the output if the source is Gray-coded or held quasi-static.
   for (genvar i = 0; i < Width; i++) begin : g_bit
      bit_sync_cell #(
         .NUM_Stages (NUM_Stages)
      ) u_cell (
         .CLK     (CLK),
         .Reset   (Reset),
         .async_i (Async_data[i]),
         .sync_o  (sync_data[i])
      );
   end

endmodule

// File: tb/tb_synchronizer.sv
// Testbench for synchronizer: a 6-stage x 9-bit instance and a default instance.
// Expected outputs come from per-instance scoreboard queues of future outputs.
// Inputs are driven on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_synchronizer;

   localparam int S_A = 6;
   localparam int W_A = 9;

   logic           clk = 1'b0;
   logic           rst;
   logic [W_A-1:0] a_d;
   logic           b_d;
   logic [W_A-1:0] sync_a;
   logic           sync_b;

   logic [W_A-1:0] sb_a[$];
   logic           sb_b[$];
   bit             armed = 1'b0;
   int             chk_cnt = 0;
   int             pass_cnt = 0;
   int             cyc = 0;
   logic [W_A-1:0] last_a;
   logic           last_b;

   always #5 clk = ~clk;

   synchronizer #(.NUM_Stages(S_A), .Width(W_A)) u_dut_a (
      .CLK        (clk),
      .Reset      (rst),
      .Async_data (a_d),
      .sync_data  (sync_a)
   );

   synchronizer u_dut_b (
      .CLK        (clk),
      .Reset      (rst),
      .Async_data (b_d),
      .sync_data  (sync_b)
   );

   task automatic check9(input string tag, input logic [W_A-1:0] obs, input logic [W_A-1:0] exp);
      chk_cnt++;
      assert (obs === exp) begin
         pass_cnt++;
      end else begin
         $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      chk_cnt++;
      assert (obs === exp) begin
         pass_cnt++;
      end else begin
         $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // One clock of stimulus for both instances; instance B toggles every 4 cycles.
   task automatic step(input logic r, input logic [W_A-1:0] d);
      logic [W_A-1:0] exp_a;
      logic           exp_b;
      @(negedge clk);
      // Outputs must not have moved since just after the rising edge.
      if (armed) begin
         check9("hold_a", sync_a, last_a);
         check1("hold_b", sync_b, last_b);
      end
      rst = r;
      a_d = d;
      b_d = ((cyc >> 2) & 1) != 0;
      @(posedge clk);
      #1;
      cyc++;
      if (r) begin
         // A reset edge makes this output and the next S-1 outputs zero.
         sb_a.delete();
         sb_b.delete();
         repeat (S_A) sb_a.push_back('0);
         repeat (2) sb_b.push_back(1'b0);
         armed = 1'b1;
      end else if (armed) begin
         // A value sampled now is due S-1 edges later.
         sb_a.push_back(d);
         sb_b.push_back(b_d);
      end
      if (armed) begin
         exp_a = sb_a.pop_front();
         exp_b = sb_b.pop_front();
         check9("pipe_a", sync_a, exp_a);
         check1("pipe_b", sync_b, exp_b);
      end
      last_a = sync_a;
      last_b = sync_b;
   endtask

   initial begin
      logic [W_A-1:0] vals[3];
      rst = 1'b0;
      a_d = '0;
      b_d = 1'b0;
      vals[0] = 9'h000;
      vals[1] = 9'h155;
      vals[2] = 9'h0AA;

      // Reset and a data change on the same edge: reset wins.
      step(1'b1, 9'h1FF);
      check9("rst_same_edge", sync_a, 9'h000);
      // Held 9'h1FF: zero after 5 edges, full value after the 6th.
      repeat (5) begin
         step(1'b0, 9'h1FF);
         check9("lat_before_6", sync_a, 9'h000);
      end
      step(1'b0, 9'h1FF);
      check9("lat_at_6", sync_a, 9'h1FF);
      repeat (3) step(1'b0, 9'h1FF);

      // One-edge reset pulse from a steady output, then refill.
      step(1'b1, 9'h1FF);
      check9("rst_pulse_clears", sync_a, 9'h000);
      repeat (5) begin
         step(1'b0, 9'h1FF);
         check9("refill_before_6", sync_a, 9'h000);
      end
      step(1'b0, 9'h1FF);
      check9("refill_at_6", sync_a, 9'h1FF);

      // Reset held for 3 edges keeps the output at zero.
      repeat (3) begin
         step(1'b1, 9'h1FF);
         check9("rst_held", sync_a, 9'h000);
      end
      repeat (5) begin
         step(1'b0, 9'h1FF);
         check9("release_before_6", sync_a, 9'h000);
      end
      step(1'b0, 9'h1FF);
      check9("release_at_6", sync_a, 9'h1FF);

      // Stepped patterns, each held 8 cycles.
      foreach (vals[k]) begin
         repeat (8) step(1'b0, vals[k]);
      end
      check9("pattern_0aa", sync_a, 9'h0AA);

      // Random data with occasional resets.
      for (int n = 0; n < 80; n++) begin
         step($urandom_range(0, 15) == 0, W_A'($urandom));
      end
      repeat (S_A + 2) step(1'b0, 9'h123);
      check9("final_value", sync_a, 9'h123);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/synchronizer.md
SYNCHRONIZER -- requirements
Module: synchronizer

Interface
REQ-001 Parameter NUM_Stages, default 2, number of flip-flop stages per bit (synchronizer depth).
REQ-002 Parameter Width, default 1, number of independent bits synchronized.
REQ-003 CLK  input  1  destination-domain clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset; one clock; sampled on rising CLK edge.
REQ-005 Async_data  input  Width  data from an asynchronous domain; may change at any time.
REQ-006 sync_data  output  Width  synchronized copy of Async_data, driven directly by the last stage register.

Function
REQ-007 Each bit i SHALL pass through its own chain of NUM_Stages D flip-flops clocked by CLK: stage0 <= Async_data[i], stage k <= stage k-1.
REQ-008 sync_data[i] SHALL equal the output of stage NUM_Stages-1 of bit i; no combinational path from Async_data to sync_data.
REQ-009 Latency: a value held stable on Async_data across NUM_Stages consecutive rising edges SHALL appear on sync_data immediately after the NUM_Stages-th edge, and not earlier.
REQ-010 Bits SHALL be treated independently; no cross-bit encoding, gating or coherency logic (multi-bit coherency is the user's responsibility, e.g., Gray-coded or quasi-static data).
REQ-011 Output SHALL change only on rising CLK edges; no glitches between edges.
REQ-012 Reset and data change on the same edge: Reset SHALL take priority; all stages load 0.
REQ-013 Reset deasserted mid-operation: pipeline refills from zero; first valid sample appears NUM_Stages edges after the first non-reset edge.
REQ-014 NUM_Stages < 2 or Width < 1 SHALL cause an elaboration-time error.

Reset
REQ-015 When Reset=1 at a rising CLK edge, every stage of every bit SHALL load 0, so sync_data = 0 after that edge.
REQ-016 Reset SHALL be ignored between clock edges (purely synchronous); before the first reset edge register contents are undefined.
REQ-017 Reset SHALL hold state at zero for as long as it remains asserted.

Structure
REQ-018 A shared package SHALL hold default constants for NUM_Stages (2) and Width (1), used by this block and its users.
REQ-019 A sub-module bit_sync_cell (single-bit, NUM_Stages-deep chain with CLK/Reset) SHALL be instantiated Width times via a generate loop.
REQ-020 Stage registers SHALL carry tool attributes marking them as synchronizer registers (ASYNC_REG or equivalent) and be kept free of retiming/duplication.

Verification
REQ-021 NUM_Stages=6, Width=9: Reset pulse, Async_data=9'h1FF held -> sync_data=0 after 5 edges, sync_data=9'h1FF after 6th edge.
REQ-022 Reset held high 3 edges while Async_data=9'h1FF -> sync_data stays 0; after release, 9'h1FF appears exactly 6 edges later.
REQ-023 Steady 9'h1FF output, assert Reset for one edge -> sync_data=0 next edge; refills to 9'h1FF 6 edges after release.
REQ-024 Async_data stepped 9'h000 -> 9'h155 -> 9'h0AA, each held 8 cycles -> sync_data reproduces each value delayed exactly 6 cycles, per-bit.
REQ-025 NUM_Stages=2, Width=1 defaults: single-bit toggle every 4 cycles -> output toggles 2 cycles later; no output change between edges.
REQ-026 Elaborate with NUM_Stages=1 -> elaboration error reported.
